// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT framing path.
// Provides sample/frame sizing defaults, sample_t and frame_state_e.
package fft_pkg;

    localparam int DEF_SAMPLES = 16;
    localparam int DEF_WIDTH   = 32;

    typedef logic signed [DEF_WIDTH-1:0] sample_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } frame_state_e;

endpackage

// File: rtl/fft_frame_collector_if.sv
// Sample stream in, parallel frame out, both valid/ready.
// Ports: in_data/in_valid/in_ready, frame/frame_valid/frame_ready.
// master = producer/FFT side, slave = the collector.
interface fft_frame_collector_if
    import fft_pkg::*;
#(
    parameter int SAMPLES = DEF_SAMPLES,
    parameter int WIDTH   = DEF_WIDTH
);

    logic [WIDTH-1:0]              in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [SAMPLES-1:0][WIDTH-1:0] frame;
    logic                          frame_valid;
    logic                          frame_ready;

    modport master (
        output in_data,
        output in_valid,
        output frame_ready,
        input  in_ready,
        input  frame,
        input  frame_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  frame_ready,
        output in_ready,
        output frame,
        output frame_valid
    );

endinterface

// File: rtl/fft_frame_collector.sv
// Collects SAMPLES beats into a frame; double-buffered (fill + output reg).
// Ports: clk, rst (async, active-low), bus (slave), frames_out (handoffs).
// Option: FFT_FRAME_OVERLAP_EN enables 50% frame overlap.
module fft_frame_collector
    import fft_pkg::*;
#(
    parameter int SAMPLES = DEF_SAMPLES,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_frame_collector_if.slave  bus,
    output logic [15:0]           frames_out
);

    localparam int IW   = $clog2(SAMPLES);
    localparam int HALF = SAMPLES / 2;

    localparam logic [IW-1:0] LAST = IW'(SAMPLES - 1);
`ifdef FFT_FRAME_OVERLAP_EN
    localparam logic [IW-1:0] RESTART = IW'(HALF);
`else
    localparam logic [IW-1:0] RESTART = '0;
`endif

    localparam logic [0:0] S_FILL = FILL;
    localparam logic [0:0] S_FULL = FULL;

    logic [0:0]                    r_state;
    logic [IW-1:0]                 r_wr_idx;
    logic [SAMPLES-1:0][WIDTH-1:0] r_fill;
    logic [SAMPLES-1:0][WIDTH-1:0] r_frame;
    logic                          r_frame_valid;
    logic [15:0]                   r_frames_out;

    logic                          w_beat;
    logic                          w_slot_free;
    logic                          w_last;
    logic                          w_xfer;
    logic [SAMPLES-1:0][WIDTH-1:0] w_fill_new;
    logic [SAMPLES-1:0]            w_wen;
    logic [SAMPLES-1:0][WIDTH-1:0] w_wdat;

    assign bus.in_ready    = (r_state == S_FILL);
    assign bus.frame       = r_frame;
    assign bus.frame_valid = r_frame_valid;
    assign frames_out      = r_frames_out;

    assign w_beat      = bus.in_valid & bus.in_ready;
    assign w_slot_free = ~r_frame_valid | bus.frame_ready;
    assign w_last      = w_beat & (r_wr_idx == LAST);
    assign w_xfer      = w_slot_free
                       & ((r_state == S_FULL) | w_last);

    // Fill view including this cycle's beat, so a direct
    // transfer carries the final sample.
    always_comb begin
        w_fill_new = r_fill;
        for (int i = 0; i < SAMPLES; i++) begin
            if (w_beat && r_wr_idx == IW'(i)) begin
                w_fill_new[i] = bus.in_data;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < SAMPLES; i++) begin
            w_wen[i]  = w_beat && (r_wr_idx == IW'(i));
            w_wdat[i] = bus.in_data;
        end
`ifdef FFT_FRAME_OVERLAP_EN
        // Upper half slides down to seed the next frame.
        for (int i = 0; i < HALF; i++) begin
            if (w_xfer) begin
                w_wen[i]  = 1'b1;
                w_wdat[i] = w_fill_new[i+HALF];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fill <= '0;
        end else begin
            for (int i = 0; i < SAMPLES; i++) begin
                if (w_wen[i]) begin
                    r_fill[i] <= w_wdat[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_idx <= '0;
        end else if (w_xfer) begin
            r_wr_idx <= RESTART;
        end else if (w_beat) begin
            r_wr_idx <= r_wr_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FILL;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_last && !w_slot_free) begin
                        r_state <= S_FULL;
                    end
                end
                default: begin
                    if (w_slot_free) begin
                        r_state <= S_FILL;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_frames_out  <= '0;
        end else if (w_xfer) begin
            r_frame       <= w_fill_new;
            r_frame_valid <= 1'b1;
            r_frames_out  <= r_frames_out + 16'd1;
        end else if (bus.frame_ready) begin
            r_frame_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_frame_collector.sv
// Self-checking bench for fft_frame_collector.
// Reference: queue of accepted samples; frames derived arithmetically.
module tb_fft_frame_collector;

    localparam int S = 16;
    localparam int W = 32;
`ifdef FFT_FRAME_OVERLAP_EN
    localparam int STEP = S / 2;
`else
    localparam int STEP = S;
`endif

    typedef logic [S-1:0][W-1:0] frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] frames_out;

    fft_frame_collector_if #(.SAMPLES(S), .WIDTH(W)) u_if ();

    fft_frame_collector #(.SAMPLES(S), .WIDTH(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (u_if),
        .frames_out (frames_out)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] stream[$];
    int           consumed = 0;

    // Frames whose final sample has been accepted.
    function automatic int n_done();
        int k = 0;
        while (k * STEP + S <= stream.size()) k++;
        return k;
    endfunction

    function automatic logic exp_valid();
        return n_done() > consumed;
    endfunction

    function automatic logic exp_ready();
        return (n_done() - consumed) < 2;
    endfunction

    function automatic logic [15:0] exp_count();
        int c;
        c = (n_done() < consumed + 1) ? n_done() : consumed + 1;
        return 16'(c);
    endfunction

    function automatic frame_t exp_frame();
        frame_t f = '0;
        int k;
        k = exp_valid() ? consumed : consumed - 1;
        if (k >= 0)
            for (int i = 0; i < S; i++) f[i] = stream[k * STEP + i];
        return f;
    endfunction

    function automatic frame_t ramp(input int base);
        frame_t f;
        for (int i = 0; i < S; i++) f[i] = W'(base + 100 * i);
        return f;
    endfunction

    // One clock: drive at edge+1, settle, note beat/handoff, advance.
    task automatic cycle(input bit v, input logic [W-1:0] d,
                         input bit fr);
        u_if.in_valid    = v;
        u_if.in_data     = d;
        u_if.frame_ready = fr;
        #1;
        if (v && u_if.in_ready) stream.push_back(d);
        if (u_if.frame_valid && fr) consumed++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        stream.delete();
        consumed = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        u_if.in_valid = 1'b0;
        u_if.in_data = '0;
        u_if.frame_ready = 1'b0;
        #1;
        n_total++;
        if (u_if.frame_valid !== 1'b0)
            $display("FAIL rst_valid: got %b want 0", u_if.frame_valid);
        else n_pass++;
        n_total++;
        if (frames_out !== 16'd0)
            $display("FAIL rst_count: got %0d want 0", frames_out);
        else n_pass++;
        n_total++;
        if (u_if.frame !== '0)
            $display("FAIL rst_frame: got %h want 0", u_if.frame);
        else n_pass++;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_total++;
        if (u_if.in_ready !== 1'b1)
            $display("FAIL rst_ready: got %b want 1", u_if.in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ramp();
        for (int i = 0; i < S; i++) begin
            n_total++;
            if (u_if.in_ready !== 1'b1)
                $display("FAIL ramp_ready: beat %0d got %b want 1",
                         i, u_if.in_ready);
            else n_pass++;
            cycle(1'b1, W'(100 * i), 1'b1);
        end
        n_total++;
        if (u_if.frame_valid !== 1'b1)
            $display("FAIL ramp_valid: got %b want 1", u_if.frame_valid);
        else n_pass++;
        n_total++;
        if (u_if.frame !== ramp(0))
            $display("FAIL ramp_frame: got %h want %h",
                     u_if.frame, ramp(0));
        else n_pass++;
        n_total++;
        if (frames_out !== 16'd1)
            $display("FAIL ramp_count: got %0d want 1", frames_out);
        else n_pass++;
        cycle(1'b0, '0, 1'b1);
        n_total++;
        if (u_if.frame_valid !== 1'b0)
            $display("FAIL ramp_pulse: got %b want 0", u_if.frame_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        while ((n_done() - consumed) < 2 && n < 200) begin
            cycle(1'b1, $urandom, 1'b0);
            n++;
        end
        n_total++;
        if ((n_done() - consumed) != 2)
            $display("FAIL b2b_fill: timeout got %0d want 2 pending",
                     n_done() - consumed);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (u_if.in_ready !== 1'b0)
                $display("FAIL b2b_stall_ready: got %b want 0",
                         u_if.in_ready);
            else n_pass++;
            n_total++;
            if (u_if.frame !== exp_frame() || !u_if.frame_valid)
                $display("FAIL b2b_hold: got %h want %h",
                         u_if.frame, exp_frame());
            else n_pass++;
            cycle(1'b1, $urandom, 1'b0);
        end
        cycle(1'b0, '0, 1'b1);
        n_total++;
        if (u_if.frame_valid !== 1'b1 || u_if.frame !== exp_frame())
            $display("FAIL b2b_release: got %b/%h want 1/%h",
                     u_if.frame_valid, u_if.frame, exp_frame());
        else n_pass++;
        n_total++;
        if (u_if.in_ready !== 1'b1)
            $display("FAIL b2b_ready_back: got %b want 1", u_if.in_ready);
        else n_pass++;
        n_total++;
        if (frames_out !== exp_count())
            $display("FAIL b2b_count: got %0d want %0d",
                     frames_out, exp_count());
        else n_pass++;
        cycle(1'b0, '0, 1'b1);
        n_total++;
        if (u_if.frame_valid !== 1'b0)
            $display("FAIL b2b_drain: got %b want 0", u_if.frame_valid);
        else n_pass++;
    endtask

    task automatic test_direct();
        int n = 0;
        int rem;
        while (!exp_valid() && n < 100) begin
            cycle(1'b1, $urandom, 1'b0);
            n++;
        end
        rem = n_done() * STEP + S - stream.size();
        for (int j = 0; j < rem; j++)
            cycle(1'b1, $urandom, j == rem - 1);
        n_total++;
        if (u_if.frame_valid !== 1'b1 || u_if.in_ready !== 1'b1)
            $display("FAIL direct_flags: got v%b r%b want v1 r1",
                     u_if.frame_valid, u_if.in_ready);
        else n_pass++;
        n_total++;
        if (u_if.frame !== exp_frame())
            $display("FAIL direct_frame: got %h want %h",
                     u_if.frame, exp_frame());
        else n_pass++;
        n_total++;
        if (frames_out !== exp_count())
            $display("FAIL direct_count: got %0d want %0d",
                     frames_out, exp_count());
        else n_pass++;
        cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_midreset();
        int n = 0;
        while (!exp_valid() && n < 100) begin
            cycle(1'b1, $urandom | 32'h1, 1'b0);
            n++;
        end
        for (int i = 0; i < 7; i++)
            cycle(1'b1, $urandom | 32'h1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        stream.delete();
        consumed = 0;
        n_total++;
        if (u_if.frame_valid !== 1'b0 || frames_out !== 16'd0)
            $display("FAIL mid_rst_flags: got v%b c%0d want v0 c0",
                     u_if.frame_valid, frames_out);
        else n_pass++;
        n_total++;
        if (u_if.frame !== '0)
            $display("FAIL mid_rst_frame: got %h want 0", u_if.frame);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < S; i++)
            cycle(1'b1, W'(100 * i), 1'b0);
        n_total++;
        if (u_if.frame[0] !== '0 || u_if.frame !== ramp(0))
            $display("FAIL mid_ramp: got %h want %h",
                     u_if.frame, ramp(0));
        else n_pass++;
        n_total++;
        if (frames_out !== 16'd1)
            $display("FAIL mid_count: got %0d want 1", frames_out);
        else n_pass++;
        cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_random();
        int target;
        int n = 0;
        logic [15:0] base;
        base = exp_count();
        target = stream.size() + 64;
        while (stream.size() < target && n < 2000) begin
            cycle(1'($urandom), $urandom, 1'($urandom));
            n++;
            n_total++;
            if (u_if.frame_valid !== exp_valid()
                || u_if.in_ready !== exp_ready())
                $display("FAIL rnd_flags: got v%b r%b want v%b r%b",
                         u_if.frame_valid, u_if.in_ready,
                         exp_valid(), exp_ready());
            else n_pass++;
            if (exp_valid()) begin
                n_total++;
                if (u_if.frame !== exp_frame())
                    $display("FAIL rnd_frame: got %h want %h",
                             u_if.frame, exp_frame());
                else n_pass++;
            end
        end
        n = 0;
        while (exp_valid() && n < 10) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        n_total++;
        if (u_if.frame_valid !== 1'b0)
            $display("FAIL rnd_drain: got %b want 0", u_if.frame_valid);
        else n_pass++;
        n_total++;
        if (frames_out !== 16'(base + 64 / STEP))
            $display("FAIL rnd_count: got %0d want %0d",
                     frames_out, 16'(base + 64 / STEP));
        else n_pass++;
    endtask

`ifdef FFT_FRAME_OVERLAP_EN
    task automatic test_overlap();
        do_reset();
        for (int i = 0; i < 24; i++)
            cycle(1'b1, W'(100 * i), 1'b1);
        n_total++;
        if (u_if.frame !== ramp(800) || !u_if.frame_valid)
            $display("FAIL ovl_frame: got %h want %h",
                     u_if.frame, ramp(800));
        else n_pass++;
        n_total++;
        if (frames_out !== 16'd2)
            $display("FAIL ovl_count: got %0d want 2", frames_out);
        else n_pass++;
        cycle(1'b0, '0, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_direct();
        test_midreset();
        test_random();
`ifdef FFT_FRAME_OVERLAP_EN
        test_overlap();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fft_frame_collector.md
# fft_frame_collector

Upstream framing stage for `N_point_fft_seq`. Accepts one signed sample per valid/ready beat from the audio front end and assembles `SAMPLES` consecutive samples into a frame. Presents the frame as a parallel array matching the FFT's `sampleInputs` port, with a valid/ready handshake. Double-buffered: a fill buffer plus an output holding register, so collection of frame N+1 overlaps with FFT consumption of frame N.

## Interface
- `SAMPLES`, 16, frame length; power of two, ≥ 4.
- `WIDTH`, 32, sample width in bits; must equal the FFT's `WIDTH`.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  incoming sample, two's complement.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a sample this cycle.
- `frame`  out  [WIDTH-1:0] × [SAMPLES-1:0]  assembled frame; index 0 is the oldest sample. Connects to FFT `sampleInputs`.
- `frame_valid`  out  1  `frame` holds a complete, unconsumed frame.
- `frame_ready`  in  1  FFT accepts `frame` this cycle.
- `frames_out`  out  16  count of frames handed off; wraps at 0xFFFF.

## Operation
- Beat = `in_valid & in_ready`; frame handoff = `frame_valid & frame_ready`.
- On a beat, `in_data` is written to `fill[wr_idx]` and `wr_idx` increments. `wr_idx` is `$clog2(SAMPLES)` bits. No data arithmetic; samples pass through bit-exact.
- States: `FILL` and `FULL`.
- `FILL`:
  - `in_ready = 1`.
  - A beat at `wr_idx == SAMPLES-1` completes the fill buffer.
  - If the output slot is free on that edge (`!frame_valid` or a handoff in the same cycle):
    - `frame <= fill` with the final sample included;
    - `frame_valid <= 1`, `frames_out` increments;
    - `wr_idx` restarts;
    - stay in `FILL`.
  - Otherwise go to `FULL`.
- `FULL`:
  - `in_ready = 0`; `in_data` is ignored.
  - On the first edge where the slot is free: perform the transfer above and return to `FILL`.
- `frame_valid` falls on a handoff edge unless a new transfer occurs on the same edge; in that case it stays high and `frame` updates.
- `frame` is stable while `frame_valid & !frame_ready`.
- Reset, asynchronous and any time, including mid-frame:
  - state `FILL`, `wr_idx = 0`;
  - `frame_valid = 0`, `frames_out = 0`, every `frame[i] = 0`;
  - fill contents are discarded;
  - `in_ready` = 1 after reset deasserts.

## Timing
- `in_ready` is combinational from state only. It never depends on `in_valid` or `frame_ready`.
- Latency:
  - `frame_valid` is high the cycle after the edge that accepts the final sample, when the slot is free.
  - If stalled in `FULL`, it is high the cycle after the edge on which `frame_ready` was seen.
- Sustained throughput: one sample per cycle when the FFT consumes each frame within `SAMPLES` cycles. No bubble on the fill→transfer edge.
- Stall: `in_ready` is low from the cycle after the completing beat until the cycle after the freeing handoff.

## Configuration
- `FFT_FRAME_OVERLAP_EN` defined: 50 % overlap.
  - On each transfer, `fill[SAMPLES/2 +: SAMPLES/2]` is copied into `fill[0 +: SAMPLES/2]` and `wr_idx` restarts at `SAMPLES/2`.
  - Every frame after the first needs only `SAMPLES/2` new beats.
- Undefined: `wr_idx` restarts at 0 and frames are disjoint.

## Structure
- Shared package `fft_pkg`:
  - `SAMPLES`/`WIDTH` defaults;
  - `sample_t` (`logic signed [WIDTH-1:0]`);
  - `frame_state_e {FILL, FULL}`.
- Single module; no sub-module. The fill buffer and output register are plain register arrays with per-index write enables.

## Test plan
- Ramp 0,100,…,1500 on 16 back-to-back beats, `frame_ready` tied high:
  - `frame_valid` pulses one cycle after beat 16;
  - `frame[i] = 100·i`;
  - `frames_out = 1`;
  - `in_ready` never drops.
- Two frames back-to-back, `frame_ready = 0` until 10 cycles after the second frame completes:
  - `in_ready` low during that wait;
  - first frame is held stable;
  - on release, second frame appears the next cycle and `in_ready` returns high.
- `frame_ready` asserted on the same cycle as the 16th beat of the next frame: direct transfer, no `FULL` entry, `frame_valid` stays high.
- `rst` pulsed low after 7 beats: all outputs zero immediately; a following 16-beat ramp produces `frame[0] = 0`, not stale data.
- `in_valid` toggled randomly at 50 % over 64 beats: 4 frames, each containing its 16 values in order, with no loss or duplication.
- With `FFT_FRAME_OVERLAP_EN`, feed 24 beats 0,100,…,2300:
  - frame 2 = 800…2300;
  - `frames_out = 2`.
